// File: rtl/mic_pkg.sv
// mic_pkg: MIC beat layout constants, merge FSM states and the rotating-priority pick helper.
package mic_pkg;
  localparam int MIC_DATA_W = 64;
  localparam int MIC_SRC_ID_BIT = 48;
  localparam int MIC_SRC_ID_W = 3;
  localparam int MIC_SEQ_LSB = 32;
  localparam int MIC_BEAT_LSB = 16;
  typedef enum logic {ST_IDLE = 1'b0, ST_LOCKED = 1'b1} merge_state_e;
  // First set bit of req at or after start, wrapping within n requesters.
  function automatic int rr_pick(input logic [7:0] req, input int start, input int n);
    int w;
    int idx;
    w = 0;
    for (int i = 7; i >= 0; i--) begin
      idx = start + i >= n ? start + i - n : start + i;
      if (i < n && req[idx[2:0]]) w = idx;
    end
    return w;
  endfunction
endpackage

// File: rtl/i_skid.sv
// i_skid: two-entry skid buffer; in_ready comes from a register so it never sees out_ready combinationally.
module i_skid #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         skid_valid;
  logic [W-1:0] skid_data;
  assign in_ready = !skid_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_ready || !out_valid) begin
      out_valid  <= skid_valid || in_valid;
      skid_valid <= 1'b0;
    end else if (in_valid && !skid_valid) begin
      skid_valid <= 1'b1;
    end
  always_ff @(posedge clk)
    if (out_ready || !out_valid) out_data <= skid_valid ? skid_data : in_data;
    else if (in_valid && !skid_valid) skid_data <= in_data;
endmodule

// File: rtl/i_merge_n.sv
// i_merge_n: packet-atomic N:1 merge of MIC streams with round-robin or fixed-priority arbitration.
module i_merge_n
  import mic_pkg::*;
#(
  parameter int NUM_IN   = 4,
  parameter int DATA_W   = MIC_DATA_W,
  parameter int ARB_MODE = 0,
  parameter int OUT_REG  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_IN-1:0]        I_TVALID,
  output logic [NUM_IN-1:0]        I_TREADY,
  input  logic [NUM_IN*DATA_W-1:0] I_TDATA,
  input  logic [NUM_IN-1:0]        I_TLAST,
  output logic                     O_TVALID,
  input  logic                     O_TREADY,
  output logic [DATA_W-1:0]        O_TDATA,
  output logic                     O_TLAST,
  output logic [NUM_IN-1:0]        O_GRANT
);
  localparam int IW = $clog2(NUM_IN);
  merge_state_e state, state_nxt;
  logic [IW-1:0] owner, owner_nxt, ptr, ptr_nxt, winner, sel;
  logic [7:0] req;
  logic [DATA_W-1:0] sel_data;
  logic down_ready, sel_valid, fire, first_fire;
  assign req = 8'(I_TVALID);
  assign winner = IW'(rr_pick(req, ARB_MODE != 0 ? 0 : (int'(ptr) + 1) % NUM_IN, NUM_IN));
  assign sel = state == ST_LOCKED ? owner : winner;
  assign sel_data = I_TDATA[int'(sel) * DATA_W +: DATA_W];
  assign sel_valid = reset && I_TVALID[sel];
  assign fire = sel_valid && down_ready;
  assign first_fire = fire && state == ST_IDLE;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= ST_IDLE;
      owner <= '0;
      ptr   <= IW'(NUM_IN - 1);
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
    end
  // The pointer moves only when a packet's first beat is taken, never per beat.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    if (first_fire) begin
      ptr_nxt   = winner;
      owner_nxt = winner;
      state_nxt = I_TLAST[sel] ? ST_IDLE : ST_LOCKED;
    end else if (fire && I_TLAST[sel]) begin
      state_nxt = ST_IDLE;
    end
  end
  always_comb begin
    I_TREADY = '0;
    O_GRANT  = '0;
    if (reset && down_ready) I_TREADY[sel] = state == ST_LOCKED || sel_valid;
    if (state == ST_LOCKED || first_fire) O_GRANT[sel] = 1'b1;
  end
  if (OUT_REG != 0) begin : g_reg
    logic [DATA_W:0] sk_out;
    i_skid #(.W(DATA_W + 1)) u_skid (
      .clk      (clk),
      .rst_n    (reset),
      .in_valid (sel_valid),
      .in_ready (down_ready),
      .in_data  ({I_TLAST[sel], sel_data}),
      .out_valid(O_TVALID),
      .out_ready(O_TREADY),
      .out_data (sk_out)
    );
    assign O_TLAST = sk_out[DATA_W];
    assign O_TDATA = sk_out[DATA_W-1:0];
  end else begin : g_comb
    assign down_ready = O_TREADY;
    assign O_TVALID   = sel_valid;
    assign O_TDATA    = sel_data;
    assign O_TLAST    = I_TLAST[sel];
  end
endmodule

// File: tb/tb_i_merge_n.sv
// tb_i_merge_n: randomized merge bench with per-source scoreboard plus fixed-priority and pass-through side instances.
module tb_i_merge_n;
  import mic_pkg::*;
  localparam int N = 4;
  localparam int DW = 64;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] iv, ir, il, og;
  logic [N*DW-1:0] idata;
  logic ov, ordy, ol;
  logic [DW-1:0] od;
  i_merge_n #(.NUM_IN(N), .DATA_W(DW), .ARB_MODE(0), .OUT_REG(1)) u_dut (
    .clk(clk), .reset(reset), .I_TVALID(iv), .I_TREADY(ir), .I_TDATA(idata), .I_TLAST(il),
    .O_TVALID(ov), .O_TREADY(ordy), .O_TDATA(od), .O_TLAST(ol), .O_GRANT(og));

  logic [3:0] fp_iv, fp_ir, fp_il, fp_og;
  logic [31:0] fp_id;
  logic fp_ov, fp_ordy, fp_ol;
  logic [7:0] fp_od;
  i_merge_n #(.NUM_IN(4), .DATA_W(8), .ARB_MODE(1), .OUT_REG(1)) u_fp (
    .clk(clk), .reset(reset), .I_TVALID(fp_iv), .I_TREADY(fp_ir), .I_TDATA(fp_id), .I_TLAST(fp_il),
    .O_TVALID(fp_ov), .O_TREADY(fp_ordy), .O_TDATA(fp_od), .O_TLAST(fp_ol), .O_GRANT(fp_og));

  logic [1:0] cb_iv, cb_ir, cb_il, cb_og;
  logic [15:0] cb_id;
  logic cb_ov, cb_ordy, cb_ol;
  logic [7:0] cb_od;
  i_merge_n #(.NUM_IN(2), .DATA_W(8), .ARB_MODE(0), .OUT_REG(0)) u_cb (
    .clk(clk), .reset(reset), .I_TVALID(cb_iv), .I_TREADY(cb_ir), .I_TDATA(cb_id), .I_TLAST(cb_il),
    .O_TVALID(cb_ov), .O_TREADY(cb_ordy), .O_TDATA(cb_od), .O_TLAST(cb_ol), .O_GRANT(cb_og));

  logic [64:0] txq[N][$];
  logic [64:0] expq[N][$];
  int total = 0;
  int bad = 0;
  int nout = 0;
  int rr_last = N - 1;
  int cur_src = 0;
  int msrc;
  bit rr_chk = 0;
  bit in_pkt = 0;
  bit pv = 0;
  bit rnd_gap = 0;
  bit rnd_rdy = 0;
  logic [3:0] gap = '0;
  logic [DW-1:0] pd;
  logic pl;

  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Queue one packet for the driver and the same beats as the expected stream of that source.
  task automatic send(input int src, input int len, input int id);
    logic [63:0] d;
    for (int b = 0; b < len; b++) begin
      d = {$urandom, $urandom};
      d[MIC_SRC_ID_BIT +: MIC_SRC_ID_W] = src[2:0];
      d[MIC_SEQ_LSB +: 8] = id[7:0];
      d[MIC_BEAT_LSB +: 8] = b[7:0];
      txq[src].push_back({b == len - 1, d});
      expq[src].push_back({b == len - 1, d});
    end
  endtask

  task automatic drain(input string nm);
    int pend;
    pend = 1;
    for (int i = 0; i < 3000 && pend != 0; i++) begin
      @(negedge clk);
      pend = 0;
      for (int c = 0; c < N; c++) pend += expq[c].size() + txq[c].size();
    end
    chk(nm, 72'(pend), 72'(0));
  endtask

  initial begin : driver
    logic [N-1:0] fin;
    logic [N-1:0] gr;
    logic [64:0] h;
    iv = '0;
    idata = '0;
    il = '0;
    ordy = 1'b1;
    gr = '0;
    forever begin
      @(negedge clk);
      fin = iv & ir;
      @(posedge clk);
      #1;
      for (int c = 0; c < N; c++) begin
        if (fin[c] && txq[c].size() > 0) void'(txq[c].pop_front());
        gr[c] = rnd_gap && ($urandom_range(3) == 0);
        h = txq[c].size() > 0 ? txq[c][0] : '0;
        iv[c] = txq[c].size() > 0 && !gap[c] && !gr[c];
        idata[c*DW +: DW] = h[63:0];
        il[c] = h[64];
      end
      ordy = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      pv = 0;
      in_pkt = 0;
    end else begin
      if (pv) chk("hold", {ov, ol, od}, {1'b1, pl, pd});
      pv = ov && !ordy;
      pd = od;
      pl = ol;
      if (ov && ordy) begin
        msrc = int'(od[MIC_SRC_ID_BIT +: MIC_SRC_ID_W]);
        nout++;
        if (in_pkt) chk("interleave", 72'(msrc), 72'(cur_src));
        else if (rr_chk) begin
          chk("rr_order", 72'(msrc), 72'((rr_last + 1) % N));
          rr_last = msrc;
        end
        if (msrc >= N || expq[msrc].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %h want none", {ol, od});
        end else chk("beat", {ol, od}, expq[msrc].pop_front());
        in_pkt = !ol;
        cur_src = msrc;
      end
    end
  end

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : test
    int seed_v, n0, t0, t1;
    bit found;
    fp_iv = 4'b1001;
    fp_id = {8'h13, 8'h12, 8'h11, 8'h10};
    fp_il = '1;
    fp_ordy = 1'b1;
    cb_iv = 2'b11;
    cb_id = {8'hB1, 8'hA0};
    cb_il = '1;
    cb_ordy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ovalid", 72'(ov), 72'(0));
    chk("rst_grant", 72'(og), 72'(0));
    chk("rst_fp_ready", 72'(fp_ir), 72'(0));
    chk("rst_cb_ready", 72'(cb_ir), 72'(0));
    chk("rst_cb_valid", 72'(cb_ov), 72'(0));
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("cb_valid", 72'(cb_ov), 72'(1));
      chk("cb_grant", 72'(cb_og), 72'(k % 2 ? 2'b10 : 2'b01));
      chk("cb_ready", 72'(cb_ir), 72'(k % 2 ? 2'b10 : 2'b01));
      chk("cb_data", 72'({cb_ol, cb_od}), 72'(k % 2 ? 9'h1B1 : 9'h1A0));
      chk("fp_grant", 72'(fp_og), 72'(4'b0001));
      chk("fp_ready", 72'(fp_ir), 72'(4'b0001));
      if (k > 0) chk("fp_data", 72'({fp_ov, fp_ol, fp_od}), 72'(10'h310));
    end
    @(posedge clk);
    #1;
    cb_iv = '0;
    fp_iv = '0;
    // All four sources loaded at once: rotation must be 0,1,2,3,0,... with no bubbles.
    #1;
    rr_chk = 1;
    n0 = nout;
    for (int p = 0; p < 2; p++) for (int c = 0; c < N; c++) send(c, 3, p);
    t0 = -1;
    for (int i = 0; i < 300 && nout - n0 < 24; i++) begin
      @(posedge clk);
      #2;
      if (t0 < 0 && nout > n0) t0 = cyc;
    end
    t1 = cyc;
    chk("rr_beats", 72'(nout - n0), 72'(24));
    chk("rr_span", 72'(t1 - t0), 72'(23));
    rr_chk = 0;
    drain("rr_drain");
    @(posedge clk);
    #2;
    send(1, 4, 7);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = og == 4'b0010;
    end
    chk("lock_seen", 72'(found), 72'(1));
    gap[1] = 1'b1;
    send(2, 2, 8);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_grant", 72'(og), 72'(4'b0010));
      chk("lock_block", 72'({iv[2], ir[2]}), 72'(2'b10));
    end
    gap[1] = 1'b0;
    drain("lock_drain");
    seed_v = $urandom(32'hbeef);
    rnd_rdy = 1;
    rnd_gap = 1;
    for (int p = 0; p < 6; p++) for (int c = 0; c < 3; c++) send(c, $urandom_range(4, 1), 16 + p);
    drain("rand_drain");
    rnd_rdy = 0;
    rnd_gap = 0;
    @(posedge clk);
    #2;
    send(2, 5, 9);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = og == 4'b0100;
    end
    chk("ch2_seen", 72'(found), 72'(1));
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_valid", 72'(ov), 72'(0));
    chk("mid_rst_grant", 72'(og), 72'(0));
    chk("mid_rst_ready", 72'({iv[2], ir}), 72'(5'b10000));
    #1;
    for (int c = 0; c < N; c++) begin
      txq[c].delete();
      expq[c].delete();
    end
    send(1, 1, 11);
    send(0, 1, 10);
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", 72'(og), 72'(4'b0001));
    drain("post_rst_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
